pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Receive-side counterpart of the team's PWM generator: measures an incoming PWM waveform and reports period, high time and integer duty percentage.
- Sits downstream of a PWM source (on-board or external pin) and feeds status and logging logic with one result per completed PWM period.
- Detects a dead or stuck input through a timeout.

Parameters:
- CNT_W, 16, width of the period and high-time counters/outputs.
- TIMEOUT, 1000, cycles without a rising edge before the input is declared stuck; must satisfy 2 <= TIMEOUT < 2^CNT_W.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- pwm_in  input  1  PWM input, asynchronous to clk.
- period_out  output  CNT_W  cycles between the two rising edges of the last measured period.
- high_out  output  CNT_W  cycles pwm_in was high within that period.
- duty_pct  output  7  floor(high_out*100/period_out), range 0..99.
- meas_valid  output  1  one-cycle pulse; period_out, high_out and duty_pct are updated on this cycle.
- overrun  output  1  one-cycle pulse; a period closed while the divider was busy and was discarded.
- stuck  output  1  level; timeout occurred, held until the next rising edge.
- stuck_lvl  output  1  synchronized pwm_in level at the timeout; valid while stuck=1.

Behaviour:
- Reset: all outputs 0, synchronizer flops 0, state IDLE, counters 0, divider idle.
- Input path: pwm_in -> s1 -> s2 (two-flop synchronizer) -> s3. rise = s2 & ~s3. All measurement uses s2; the fixed synchronizer latency cancels out.
- States:
  - IDLE: wait for rise. On rise: per_cnt<=1, hi_cnt<=1, stuck<=0, go to MEAS. No result is produced for this first edge.
  - MEAS, no rise: per_cnt<=per_cnt+1; hi_cnt<=hi_cnt+s2.
  - MEAS, rise: close the period with period=per_cnt and high=hi_cnt (pre-update values). Then restart with per_cnt<=1 and hi_cnt<=1.
  - MEAS timeout: when per_cnt==TIMEOUT and there is no rise, go to IDLE, stuck<=1, stuck_lvl<=s2. Any in-flight division still completes.
- Counter bounds: counters never exceed TIMEOUT, so no wrap is possible.
- High-time semantics:
  - Multiple high pulses inside one period are summed into hi_cnt.
  - 1 <= high <= period-1 always holds, because the cycle before a rise has s2=0.
- Divider: restoring divider computing (high*100)/period. The numerator is CNT_W+7 bits wide, with one quotient bit per cycle.
  - Closing cycle t: latch high/period into the divider; divider busy from t+1 to t+CNT_W+8.
  - On cycle t+CNT_W+8 (t+24 at default), meas_valid=1 and all three result outputs update together. They hold until the next meas_valid.
  - A period closing on the same cycle as meas_valid is accepted: the divider reloads seamlessly.
  - A period closing while the divider is busy, before that cycle: the result is discarded and overrun pulses on the closing cycle. Counters still restart normally.
  - Periods >= CNT_W+8 cycles therefore never overrun.
- Reset mid-operation: asynchronous rst aborts any division and measurement immediately. No meas_valid is produced afterwards for the aborted period. The first rise after reset only arms measurement.
- Simultaneous meas_valid and overrun cannot occur on the same cycle, except when the divider is reloaded on its completion cycle. In that case meas_valid=1 and overrun=0.

Test Plan:
- Period 100 cycles, high 30, repeated 3 periods -> two meas_valid pulses (first edge only arms), each period_out=100, high_out=30, duty_pct=30, 24 cycles after the closing edge; overrun never asserted.
- Period 3, high 1 -> overrun pulses on closing edges that fall inside the 24-cycle busy window. The accepted result is period_out=3, high_out=1, duty_pct=33. Separately, period 24 high 12 -> every period reported, duty_pct=50, no overrun.
- Two 5-cycle high pulses within a 200-cycle period -> high_out=10, duty_pct=5.
- Input held high for 1500 cycles after a rise -> stuck=1 and stuck_lvl=1 exactly TIMEOUT cycles after that rise. The next rise clears stuck and produces no result. Repeat with the input held low -> stuck_lvl=0.
- rst asserted 10 cycles into a division -> all outputs 0 immediately, no meas_valid follows. After release, the first full period is reported correctly.
- Period 65000 with TIMEOUT=65535, CNT_W=16, high 64999 -> period_out=65000, high_out=64999, duty_pct=99.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input,
// derives the integer duty percentage with a serial divider and flags a stuck input.
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic [6:0]       duty_pct,
  output logic             meas_valid,
  output logic             overrun,
  output logic             stuck,
  output logic             stuck_lvl
);

  localparam int NUM_W = CNT_W + 7;
  localparam int DC_W  = $clog2(NUM_W + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MEAS = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [DC_W-1:0]  DC_ZERO   = DC_W'(1'b0);
  localparam logic [DC_W-1:0]  DC_ONE    = DC_W'(1'b1);
  localparam logic [DC_W-1:0]  STEP_LAST = DC_W'(NUM_W - 1);
  localparam logic [DC_W-1:0]  STEP_DONE = DC_W'(NUM_W);
  localparam logic [NUM_W-1:0] PCT_SCALE = NUM_W'(7'd100);

  logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d;
  logic             busy_q, busy_d;
  logic [DC_W-1:0]  div_cnt_q, div_cnt_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] den_q, den_d, rem_q, rem_d, res_hi_q, res_hi_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic [6:0]       duty_q, duty_d;
  logic             meas_valid_q, meas_valid_d, overrun_q, overrun_d;
  logic             stuck_q, stuck_d, stuck_lvl_q, stuck_lvl_d;

  logic             rise_s, rise_next_s, close_s, accept_s;
  logic [NUM_W-1:0] prod_s, num_next_s;
  logic [CNT_W:0]   rem_shift_s, sub_s;
  logic [CNT_W-1:0] rem_next_s;
  logic             q_bit_s;

  // Synchronizer and measurement FSM next-state logic.
  always_comb begin
    s1_d        = pwm_in;
    s2_d        = s1_q;
    s3_d        = s2_q;
    rise_s      = s2_q & ~s3_q;
    state_d     = state_q;
    per_cnt_d   = per_cnt_q;
    hi_cnt_d    = hi_cnt_q;
    stuck_d     = stuck_q;
    stuck_lvl_d = stuck_lvl_q;
    close_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise_s) begin
          state_d   = ST_MEAS;
          per_cnt_d = CNT_ONE;
          hi_cnt_d  = CNT_ONE;
          stuck_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEAS: begin
        if (rise_s) begin
          close_s   = 1'b1;
          per_cnt_d = CNT_ONE;
          hi_cnt_d  = CNT_ONE;
        end else if (per_cnt_q == TIMEOUT_C) begin
          state_d     = ST_IDLE;
          stuck_d     = 1'b1;
          stuck_lvl_d = s2_q;
        end else begin
          per_cnt_d = per_cnt_q + CNT_ONE;
          hi_cnt_d  = hi_cnt_q + {{(CNT_W-1){1'b0}}, s2_q};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Restoring divider: high*100 / period, one quotient bit per cycle.
  always_comb begin
    prod_s       = NUM_W'(hi_cnt_q) * PCT_SCALE;
    rem_shift_s  = {rem_q, num_q[NUM_W-1]};
    sub_s        = rem_shift_s - {1'b0, den_q};
    q_bit_s      = ~sub_s[CNT_W];
    rem_next_s   = q_bit_s ? sub_s[CNT_W-1:0] : rem_shift_s[CNT_W-1:0];
    num_next_s   = {num_q[NUM_W-2:0], q_bit_s};
    accept_s     = close_s & (~busy_q | (div_cnt_q == STEP_DONE));
    busy_d       = busy_q;
    div_cnt_d    = div_cnt_q;
    num_d        = num_q;
    den_d        = den_q;
    rem_d        = rem_q;
    res_hi_d     = res_hi_q;
    period_d     = period_q;
    high_d       = high_q;
    duty_d       = duty_q;
    meas_valid_d = 1'b0;
    if (accept_s) begin
      busy_d    = 1'b1;
      div_cnt_d = DC_ZERO;
      num_d     = prod_s;
      den_d     = per_cnt_q;
      rem_d     = {CNT_W{1'b0}};
      res_hi_d  = hi_cnt_q;
    end else if (busy_q) begin
      if (div_cnt_q == STEP_DONE) begin
        busy_d = 1'b0;
      end else begin
        num_d     = num_next_s;
        rem_d     = rem_next_s;
        div_cnt_d = div_cnt_q + DC_ONE;
        if (div_cnt_q == STEP_LAST) begin
          meas_valid_d = 1'b1;
          period_d     = den_q;
          high_d       = res_hi_q;
          duty_d       = num_next_s[6:0];
        end else begin
          meas_valid_d = 1'b0;
        end
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Overrun is predicted one cycle ahead (s1/s2 foretell next cycle's rise)
  // so the registered pulse lands exactly on the discarded closing cycle.
  always_comb begin
    rise_next_s = s1_q & ~s2_q;
    overrun_d   = rise_next_s & (state_d == ST_MEAS) & busy_d & (div_cnt_d != STEP_DONE);
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      state_q      <= ST_IDLE;
      per_cnt_q    <= {CNT_W{1'b0}};
      hi_cnt_q     <= {CNT_W{1'b0}};
      busy_q       <= 1'b0;
      div_cnt_q    <= DC_ZERO;
      num_q        <= {NUM_W{1'b0}};
      den_q        <= {CNT_W{1'b0}};
      rem_q        <= {CNT_W{1'b0}};
      res_hi_q     <= {CNT_W{1'b0}};
      period_q     <= {CNT_W{1'b0}};
      high_q       <= {CNT_W{1'b0}};
      duty_q       <= 7'd0;
      meas_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      stuck_q      <= 1'b0;
      stuck_lvl_q  <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      busy_q       <= busy_d;
      div_cnt_q    <= div_cnt_d;
      num_q        <= num_d;
      den_q        <= den_d;
      rem_q        <= rem_d;
      res_hi_q     <= res_hi_d;
      period_q     <= period_d;
      high_q       <= high_d;
      duty_q       <= duty_d;
      meas_valid_q <= meas_valid_d;
      overrun_q    <= overrun_d;
      stuck_q      <= stuck_d;
      stuck_lvl_q  <= stuck_lvl_d;
    end
  end

  assign period_out = period_q;
  assign high_out   = high_q;
  assign duty_pct   = duty_q;
  assign meas_valid = meas_valid_q;
  assign overrun    = overrun_q;
  assign stuck      = stuck_q;
  assign stuck_lvl  = stuck_lvl_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: default instance for most scenarios, a
// wide-timeout instance for the near-full-scale period.
module tb_pwm_capture;

  localparam int TO = 1000;

  logic        clk, rst, pwm_in, pwm_b;
  logic [15:0] period_out, high_out, period_b, high_b;
  logic [6:0]  duty_pct, duty_b;
  logic        meas_valid, overrun, stuck, stuck_lvl;
  logic        meas_valid_b, overrun_b, stuck_b, stuck_lvl_b;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int ov_cnt   = 0;
  int both_cnt = 0;
  int last_rise_cyc;
  int mv_per[$], mv_hi[$], mv_duty[$], mv_cyc[$], ov_cyc[$];

  pwm_capture #(.CNT_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .period_out(period_out), .high_out(high_out), .duty_pct(duty_pct),
    .meas_valid(meas_valid), .overrun(overrun), .stuck(stuck), .stuck_lvl(stuck_lvl)
  );

  pwm_capture #(.CNT_W(16), .TIMEOUT(65535)) dut_big (
    .clk(clk), .rst(rst), .pwm_in(pwm_b),
    .period_out(period_b), .high_out(high_b), .duty_pct(duty_b),
    .meas_valid(meas_valid_b), .overrun(overrun_b), .stuck(stuck_b), .stuck_lvl(stuck_lvl_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every result and overrun pulse of the default instance.
  always @(negedge clk) begin
    if (meas_valid) begin
      mv_per.push_back(int'(period_out));
      mv_hi.push_back(int'(high_out));
      mv_duty.push_back(int'(duty_pct));
      mv_cyc.push_back(cyc);
    end
    if (overrun) begin
      ov_cnt++;
      ov_cyc.push_back(cyc);
    end
    if (meas_valid && overrun) both_cnt++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_res(input string tag, input int idx, input int p, input int h, input int d);
    if (idx < mv_per.size()) begin
      check({tag, "_period"}, mv_per[idx], p);
      check({tag, "_high"}, mv_hi[idx], h);
      check({tag, "_duty"}, mv_duty[idx], d);
    end else begin
      check({tag, "_present"}, mv_per.size(), idx + 1);
    end
  endtask

  // Called on a negedge; each level is seen by exactly hi/lo rising edges.
  task automatic pulse(input int hi, input int lo);
    pwm_in = 1'b1;
    last_rise_cyc = cyc;
    repeat (hi) @(negedge clk);
    pwm_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int base, ov0, r1, r2, c, c2, found;
    int rises[18];
    rst = 1'b1; pwm_in = 1'b0; pwm_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_period", int'(period_out), 0);
    check("rst_high", int'(high_out), 0);
    check("rst_duty", int'(duty_pct), 0);
    check("rst_flags", int'({meas_valid, overrun, stuck, stuck_lvl}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Period 100 / high 30, three periods: first edge only arms.
    base = mv_per.size(); ov0 = ov_cnt;
    pulse(30, 70);
    pulse(30, 70); r1 = last_rise_cyc;
    pulse(30, 70); r2 = last_rise_cyc;
    check("p100_count", mv_per.size() - base, 2);
    check_res("p100_a", base, 100, 30, 30);
    check_res("p100_b", base + 1, 100, 30, 30);
    if (mv_cyc.size() > base + 1) begin
      check("p100_lat_a", mv_cyc[base], r1 + 26);
      check("p100_lat_b", mv_cyc[base + 1], r2 + 26);
    end else begin
      check("p100_lat_present", mv_cyc.size(), base + 2);
    end
    check("p100_overrun", ov_cnt - ov0, 0);

    // Async reset 10 cycles into a division aborts it.
    base = mv_per.size();
    pwm_in = 1'b1;
    repeat (12) @(negedge clk);
    check("pre_rst_period", int'(period_out), 100);
    rst = 1'b1;
    #1;
    check("midrst_period", int'(period_out), 0);
    check("midrst_high", int'(high_out), 0);
    check("midrst_duty", int'(duty_pct), 0);
    check("midrst_flags", int'({meas_valid, overrun, stuck, stuck_lvl}), 0);
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_no_mv", mv_per.size() - base, 0);
    pulse(20, 30);
    pulse(20, 30);
    check("postrst_count", mv_per.size() - base, 1);
    check_res("postrst", base, 50, 20, 40);

    // Period 3 / high 1: accepted at offsets 0, 24, 48; the other 14 closes overrun.
    rst_pulse();
    base = mv_per.size(); ov0 = ov_cnt;
    for (int i = 0; i < 18; i++) begin
      pulse(1, 2);
      rises[i] = last_rise_cyc;
    end
    repeat (40) @(negedge clk);
    check("p3_count", mv_per.size() - base, 3);
    for (int k = 0; k < 3; k++) check_res("p3", base + k, 3, 1, 33);
    check("p3_overrun", ov_cnt - ov0, 14);
    if (ov_cyc.size() > ov0) check("p3_ov_time", ov_cyc[ov0], rises[2] + 2);
    else check("p3_ov_present", ov_cyc.size(), ov0 + 1);
    if (mv_cyc.size() > base + 2) check("p3_reload_lat", mv_cyc[base + 2], rises[17] + 26);
    else check("p3_lat_present", mv_cyc.size(), base + 3);

    // Period 24 / high 12: reload on the completion cycle, nothing lost.
    rst_pulse();
    base = mv_per.size(); ov0 = ov_cnt;
    repeat (5) pulse(12, 12);
    repeat (30) @(negedge clk);
    check("p24_count", mv_per.size() - base, 4);
    for (int k = 0; k < 4; k++) check_res("p24", base + k, 24, 12, 50);
    check("p24_overrun", ov_cnt - ov0, 0);

    // Two abutting 5-cycle high pulses in a 200-cycle period.
    rst_pulse();
    base = mv_per.size();
    repeat (2) begin
      pulse(5, 0);
      pulse(5, 190);
    end
    check("p200_count", mv_per.size() - base, 1);
    check_res("p200", base, 200, 10, 5);

    // Stuck high, then re-arm and stuck low.
    rst_pulse();
    base = mv_per.size();
    pwm_in = 1'b1; c = cyc;
    wait_cyc(c + TO + 2);
    check("stuckh_before", int'(stuck), 0);
    @(negedge clk);
    check("stuckh_at", int'(stuck), 1);
    check("stuckh_lvl", int'(stuck_lvl), 1);
    wait_cyc(c + 1500);
    pwm_in = 1'b0;
    repeat (10) @(negedge clk);
    check("stuckh_held", int'(stuck), 1);
    pwm_in = 1'b1; c2 = cyc;
    wait_cyc(c2 + 3);
    check("stuck_cleared", int'(stuck), 0);
    wait_cyc(c2 + 5);
    pwm_in = 1'b0;
    wait_cyc(c2 + TO + 2);
    check("stuckl_before", int'(stuck), 0);
    @(negedge clk);
    check("stuckl_at", int'(stuck), 1);
    check("stuckl_lvl", int'(stuck_lvl), 0);
    check("stuck_no_mv", mv_per.size() - base, 0);

    // Near-full-scale period on the wide-timeout instance.
    pwm_b = 1'b1;
    repeat (64999) @(negedge clk);
    pwm_b = 1'b0;
    @(negedge clk);
    pwm_b = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (meas_valid_b) found = 1;
    end
    check("big_mv_seen", found, 1);
    check("big_period", int'(period_b), 65000);
    check("big_high", int'(high_b), 64999);
    check("big_duty", int'(duty_b), 99);
    check("big_overrun", int'(overrun_b), 0);

    check("mv_ov_same_cycle", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
